fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage that wraps the program-counter register. It computes the next PC and the PC-hold control for that register. It issues in-order instruction-memory requests over a valid/ready handshake and buffers returned instructions in a 2-entry queue toward decode. Branch/jump redirects from execute flush in-flight and buffered fetches using an epoch bit.

## Interface
- WIDTH, 32, PC/address width
- ILEN, 32, instruction width

- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  asynchronous reset, active-high
- pc_in  input  WIDTH  current fetch PC from the PC register
- pc_next_out  output  WIDTH  next PC to the PC register
- pc_stall_out  output  1  hold the PC register this cycle
- redirect_in  input  1  taken branch/jump from execute
- redirect_pc_in  input  WIDTH  redirect target
- imem_req_valid_out  output  1  fetch request valid
- imem_req_addr_out  output  WIDTH  fetch address (= pc_in)
- imem_req_ready_in  input  1  memory accepts request
- imem_rsp_valid_in  input  1  response valid; in order, ≥1 cycle after acceptance
- imem_rsp_data_in  input  ILEN  instruction word
- id_valid_out  output  1  instruction available to decode
- id_instr_out  output  ILEN  instruction
- id_pc_out  output  WIDTH  PC of id_instr_out
- id_ready_in  input  1  decode accepts

## Operation
- State:
  - epoch bit
  - 2-entry request-tag FIFO of {pc, epoch}
  - outstanding count 0..2
  - 2-entry instruction buffer of {instr, pc}, with count 0..2
- Fire definitions:
  - req_fire = imem_req_valid_out & imem_req_ready_in
  - id_fire = id_valid_out & id_ready_in
- Credit rule:
  - issue_ok = (outstanding + buf_count − id_fire) < 2
  - This guarantees the instruction buffer never overflows.
- imem_req_valid_out = issue_ok & !redirect_in & !rst_in.
- imem_req_addr_out = pc_in.
- On req_fire: push {pc_in, epoch} to the tag FIFO; increment outstanding.
- On imem_rsp_valid_in:
  - Pop the tag FIFO; decrement outstanding.
  - If tag epoch == current epoch, push {imem_rsp_data_in, tag pc} into the instruction buffer.
  - Otherwise discard.
- Next-PC generation:
  - redirect_in=1: pc_next_out = {redirect_pc_in[WIDTH-1:2], 2'b00}; pc_stall_out=0.
  - Otherwise, req_fire: pc_next_out = pc_in + 4 (mod 2^WIDTH, wraps silently); pc_stall_out=0.
  - Otherwise: pc_next_out = pc_in; pc_stall_out=1.
- Redirect:
  - Toggle epoch.
  - Clear the instruction buffer (buf_count=0).
  - The tag FIFO and outstanding are kept, so stale responses drain and are dropped.
  - No request is issued in the redirect cycle.
  - id_valid_out=0 in the following cycle.
  - A response arriving in the redirect cycle carries the old epoch and is dropped.
- Outputs to decode:
  - id_valid_out = buf_count != 0.
  - id_instr_out and id_pc_out show the buffer head.
  - Head data holds stable while id_valid_out=1 & id_ready_in=0.
- Simultaneous events:
  - Response push and id pop in the same cycle: buffer count unchanged, order preserved.
  - Request fire and response in the same cycle: outstanding unchanged.
- Reset values:
  - epoch=0, outstanding=0, buf_count=0, tag FIFO empty.
  - id_valid_out=0, imem_req_valid_out=0, pc_stall_out=1 while rst_in=1.
  - id_instr_out and id_pc_out = 0.
- Reset mid-operation:
  - All in-flight state is discarded immediately.
  - The memory must be reset alongside, so no responses arrive after reset deasserts.

## Timing
- imem_req_valid_out, pc_next_out and pc_stall_out are combinational from pc_in, redirect_in, id_ready_in and registered counts.
  - The id_ready_in → imem_req_valid_out path is combinational.
- The PC advances at the rising edge ending a req_fire cycle.
- Latency from response to decode:
  - Response captured at edge t.
  - id_valid_out=1 in cycle t+1.
- Throughput:
  - With 1-cycle memory and id_ready_in=1 constant, sustains 1 instruction/cycle after a 2-cycle fill.
- Redirect to first new request: 1 cycle.

## Test plan
- Reset release, pc_in=0x0, memory ready and 1-cycle latency, id_ready_in=1:
  - Requests to 0x0, 0x4, 0x8… on consecutive cycles.
  - id_pc_out = 0x0, 0x4, 0x8… one per cycle from cycle 2.
- id_ready_in=0 for 5 cycles:
  - Buffer fills to 2; imem_req_valid_out drops; pc_stall_out=1.
  - No instruction lost or duplicated on release.
- Redirect to 0x103 with 2 responses in flight:
  - Both stale responses dropped.
  - Next request address 0x100.
  - First decoded id_pc_out=0x100.
- imem_req_ready_in toggling randomly, variable 1–4 cycle latency:
  - Decode sees a strictly sequential PC stream.
  - outstanding never exceeds 2.
- pc_in=0xFFFFFFFC, request fires:
  - pc_next_out=0x00000000.
- rst_in asserted mid-stream with a full buffer:
  - id_valid_out=0 and imem_req_valid_out=0 in the same cycle, asynchronously.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC/hold control, in-order imem request/response
// tracking with epoch-tagged flush, and a 2-entry instruction buffer toward decode.
module fetch_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ILEN  = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_next_out,
  output logic             pc_stall_out,
  input  logic             redirect_in,
  input  logic [WIDTH-1:0] redirect_pc_in,
  output logic             imem_req_valid_out,
  output logic [WIDTH-1:0] imem_req_addr_out,
  input  logic             imem_req_ready_in,
  input  logic             imem_rsp_valid_in,
  input  logic [ILEN-1:0]  imem_rsp_data_in,
  output logic             id_valid_out,
  output logic [ILEN-1:0]  id_instr_out,
  output logic [WIDTH-1:0] id_pc_out,
  input  logic             id_ready_in
);

  localparam int unsigned CNT_W    = 2;
  localparam int unsigned CREDIT_W = 3;

  logic             epoch_q;

  logic [WIDTH-1:0] tag_pc_q [2];
  logic             tag_ep_q [2];
  logic             tag_wr_q;
  logic             tag_rd_q;
  logic [CNT_W-1:0] outst_q;

  logic [ILEN-1:0]  buf_instr_q [2];
  logic [WIDTH-1:0] buf_pc_q [2];
  logic             buf_wr_q;
  logic             buf_rd_q;
  logic [CNT_W-1:0] buf_cnt_q;

  logic                id_fire;
  logic                req_fire;
  logic                rsp_keep;
  logic [CREDIT_W-1:0] credit;
  logic                issue_ok;
  logic                unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_in[1:0];

  // Decode side: head of the instruction buffer
  always_comb begin
    id_valid_out = (buf_cnt_q != '0);
    id_instr_out = buf_instr_q[buf_rd_q];
    id_pc_out    = buf_pc_q[buf_rd_q];
    id_fire      = id_valid_out & id_ready_in;
  end

  // Credit: in-flight plus buffered entries must leave room for every response
  always_comb begin
    credit             = CREDIT_W'(outst_q) + CREDIT_W'(buf_cnt_q) - CREDIT_W'(id_fire);
    issue_ok           = (credit < CREDIT_W'(2));
    imem_req_valid_out = issue_ok & ~redirect_in & ~rst_in;
    imem_req_addr_out  = pc_in;
    req_fire           = imem_req_valid_out & imem_req_ready_in;
    rsp_keep           = imem_rsp_valid_in & ~redirect_in & (tag_ep_q[tag_rd_q] == epoch_q);
  end

  // Next-PC and hold control for the external PC register
  always_comb begin
    pc_next_out  = pc_in;
    pc_stall_out = 1'b1;
    if (!rst_in) begin
      if (redirect_in) begin
        pc_next_out  = {redirect_pc_in[WIDTH-1:2], 2'b00};
        pc_stall_out = 1'b0;
      end else if (req_fire) begin
        pc_next_out  = pc_in + WIDTH'(4);
        pc_stall_out = 1'b0;
      end
    end
  end

  // Request-tag FIFO and outstanding count; survives redirect so stale responses drain
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_pc_q[0] <= '0;
      tag_pc_q[1] <= '0;
      tag_ep_q[0] <= 1'b0;
      tag_ep_q[1] <= 1'b0;
      tag_wr_q    <= 1'b0;
      tag_rd_q    <= 1'b0;
      outst_q     <= '0;
    end else begin
      if (req_fire) begin
        tag_pc_q[tag_wr_q] <= pc_in;
        tag_ep_q[tag_wr_q] <= epoch_q;
        tag_wr_q           <= ~tag_wr_q;
      end
      if (imem_rsp_valid_in) begin
        tag_rd_q <= ~tag_rd_q;
      end
      outst_q <= outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid_in);
    end
  end

  // Epoch and instruction buffer; redirect empties the buffer and bumps the epoch
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      epoch_q        <= 1'b0;
      buf_instr_q[0] <= '0;
      buf_instr_q[1] <= '0;
      buf_pc_q[0]    <= '0;
      buf_pc_q[1]    <= '0;
      buf_wr_q       <= 1'b0;
      buf_rd_q       <= 1'b0;
      buf_cnt_q      <= '0;
    end else if (redirect_in) begin
      epoch_q   <= ~epoch_q;
      buf_rd_q  <= buf_wr_q;
      buf_cnt_q <= '0;
    end else begin
      if (rsp_keep) begin
        buf_instr_q[buf_wr_q] <= imem_rsp_data_in;
        buf_pc_q[buf_wr_q]    <= tag_pc_q[tag_rd_q];
        buf_wr_q              <= ~buf_wr_q;
      end
      if (id_fire) begin
        buf_rd_q <= ~buf_rd_q;
      end
      buf_cnt_q <= buf_cnt_q + CNT_W'(rsp_keep) - CNT_W'(id_fire);
    end
  end

endmodule
